// File: rtl/mini_pkg.sv
// Shared types and constants for the mini stimulus/checker block.
// Optional first-error capture is enabled by defining MINI_CHK_FIRST_ERR_EN.
package mini_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LFSR_W = 16;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 taps bits 0,2,3,5.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {^(q & LFSR_TAPS), q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/mini_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous seed load and advance enable.
module mini_lfsr
  import mini_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  // Seed on reset or load, otherwise shift when enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/mini_stim_chk.sv
// LFSR-driven stimulus generator with latency-matched response checker.
// Defining MINI_CHK_FIRST_ERR_EN adds first-mismatch index/observation capture.
module mini_stim_chk
  import mini_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int                NUM_VECTORS = 16,
  parameter int                LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  input  logic             y1,
  input  logic             y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef MINI_CHK_FIRST_ERR_EN
  ,
  output logic [15:0]      first_err_idx,
  output logic [3:0]       first_err_obs
`endif
);

  state_t                      state_r, state_n;
  logic [15:0]                 cnt_r, cnt_n;
  logic [2:0]                  x_r, x_n;
  logic                        busy_r, done_r, pass_r;
  logic [ERR_W-1:0]            err_r, err_n;
  logic [LATENCY-1:0][2:0]     pipe_r;
  logic [2:0]                  pipe_in_s, tail_s;
  logic                        start_acc_s, mismatch_s, run_s;
  logic [LFSR_W-1:0]           lfsr_q_s;
  logic                        unused_lfsr_s;

  assign run_s = (state_r == ST_RUN);

  mini_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_acc_s),
    .en    (run_s),
    .seed  (SEED),
    .q     (lfsr_q_s)
  );

  // Only the bits that become the next vector are consumed here.
  assign unused_lfsr_s = ^{lfsr_q_s[LFSR_W-1:4], lfsr_q_s[0]};

  // Next-state and phase counter; cnt counts vectors in RUN and cycles in DRAIN.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    start_acc_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n     = ST_RUN;
          cnt_n       = 16'd0;
          start_acc_s = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      ST_RUN: begin
        if (cnt_r == 16'(NUM_VECTORS - 1)) begin
          state_n = ST_DRAIN;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == 16'(LATENCY - 1)) begin
          state_n = ST_DONE;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 16'd0;
      end
    endcase
  end

  // Expected-response pipeline entry, tail compare, error counter and next vector.
  always_comb begin
    pipe_in_s  = {run_s, x_r[1] | x_r[2], x_r[0] & x_r[1]};
    tail_s     = pipe_r[LATENCY-1];
    mismatch_s = tail_s[2] && ((y1 != tail_s[0]) || (y2 != tail_s[1]));
    if (start_acc_s) begin
      err_n = {ERR_W{1'b0}};
    end else if (mismatch_s && (err_r != ERR_SAT)) begin
      err_n = err_r + 8'd1;
    end else begin
      err_n = err_r;
    end
    // The shift register moves right, so the next value's low bits are q[3:1].
    if (state_n == ST_RUN) begin
      x_n = start_acc_s ? SEED[2:0] : lfsr_q_s[3:1];
    end else begin
      x_n = 3'd0;
    end
  end

  // Registered state, outputs and expectation pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
      x_r     <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= {ERR_W{1'b0}};
      pipe_r  <= {LATENCY{3'b000}};
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      x_r       <= x_n;
      busy_r    <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done_r    <= (state_n == ST_DONE);
      pass_r    <= (state_n == ST_DONE) && (err_n == {ERR_W{1'b0}});
      err_r     <= err_n;
      pipe_r[0] <= pipe_in_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign {x3, x2, x1} = x_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign err_count    = err_r;

`ifdef MINI_CHK_FIRST_ERR_EN
  logic [15:0] cmp_idx_r, fe_idx_r;
  logic [3:0]  fe_obs_r;
  logic        fe_seen_r;

  // Index each compared vector and latch the first mismatch of the run.
  always_ff @(posedge clk) begin
    if (!reset || start_acc_s) begin
      cmp_idx_r <= 16'd0;
      fe_idx_r  <= 16'd0;
      fe_obs_r  <= 4'd0;
      fe_seen_r <= 1'b0;
    end else if (tail_s[2]) begin
      cmp_idx_r <= cmp_idx_r + 16'd1;
      if (mismatch_s && !fe_seen_r) begin
        fe_seen_r <= 1'b1;
        fe_idx_r  <= cmp_idx_r;
        fe_obs_r  <= {y2, y1, tail_s[1], tail_s[0]};
      end
    end
  end

  assign first_err_idx = fe_idx_r;
  assign first_err_obs = fe_obs_r;
`endif

endmodule

// File: tb/tb_mini_stim_chk.sv
// Self-checking bench for mini_stim_chk: per-cycle model compare plus directed runs.
module tb_mini_stim_chk;

  localparam int          N    = 16;
  localparam int          L    = 2;
  localparam int          NB   = 300;
  localparam int          LB   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start_b;
  logic       x1, x2, x3, y1, y2, busy, done, pass;
  logic [7:0] err_count;
  logic       xb1, xb2, xb3, yb1, yb2, busy_b, done_b, pass_b;
  logic [7:0] err_b;
`ifdef MINI_CHK_FIRST_ERR_EN
  logic [15:0] fe_idx, fe_idx_b;
  logic [3:0]  fe_obs, fe_obs_b;
`endif

  mini_stim_chk #(.SEED(SEED), .NUM_VECTORS(N), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef MINI_CHK_FIRST_ERR_EN
    , .first_err_idx(fe_idx), .first_err_obs(fe_obs)
`endif
  );

  mini_stim_chk #(.SEED(SEED), .NUM_VECTORS(NB), .LATENCY(LB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .x1(xb1), .x2(xb2), .x3(xb3), .y1(yb1), .y2(yb2),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b)
`ifdef MINI_CHK_FIRST_ERR_EN
    , .first_err_idx(fe_idx_b), .first_err_obs(fe_obs_b)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int mode   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Reference LFSR written straight from the polynomial.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Response of the device under test for a vector {x3,x2,x1}: returns {y2,y1}.
  function automatic logic [1:0] resp(input int m, input logic [2:0] v);
    logic e1, e2;
    e1 = v[0] & v[1];
    e2 = v[1] | v[2];
    case (m)
      1:       return {e2, 1'b0};
      2:       return {~e2, ~e1};
      3:       return {1'b1, e1};
      default: return {e2, e1};
    endcase
  endfunction

  function automatic bit mis(input int m, input logic [2:0] v);
    return resp(m, v) != {v[1] | v[2], v[0] & v[1]};
  endfunction

  // Ideal device: responses follow the applied vector after a fixed delay.
  logic [2:0] hist   [L]  = '{default: 3'd0};
  logic [2:0] hist_b [LB] = '{default: 3'd0};
  always @(posedge clk) begin
    hist[1]   <= hist[0];
    hist[0]   <= {x3, x2, x1};
    hist_b[2] <= hist_b[1];
    hist_b[1] <= hist_b[0];
    hist_b[0] <= {xb3, xb2, xb1};
  end
  assign {y2, y1}   = resp(mode, hist[L-1]);
  assign {yb2, yb1} = resp(2, hist_b[LB-1]);

  // Model: the run is described only by the cycle index t since the accepted start.
  logic [2:0] vec [N];
  bit known = 1'b0, active = 1'b0;
  int t = 0, run_mode = 0;
  always @(posedge clk) begin
    if (!reset) begin
      known  = 1'b1;
      active = 1'b0;
      t      = 0;
    end else if (known && start && (!active || t >= N + L)) begin
      active   = 1'b1;
      t        = 0;
      run_mode = mode;
    end else if (active) begin
      t++;
    end
  end

  logic [2:0] exp_x;
  int         exp_err;
  bit         exp_done;
  always @(negedge clk) begin
    if (known) begin
      exp_x    = (active && t < N) ? vec[t] : 3'd0;
      exp_done = active && (t >= N + L);
      exp_err  = 0;
      if (active) begin
        for (int k = 0; k < N && k <= t - 1 - L; k++) begin
          if (mis(run_mode, vec[k])) exp_err++;
        end
      end
      if (exp_err > 255) exp_err = 255;
      check("x", {x3, x2, x1}, exp_x);
      check("busy", busy, active && (t < N + L));
      check("done", done, exp_done);
      check("err_count", err_count, exp_err);
      check("pass", pass, exp_done && (exp_err == 0));
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (busy && c < 500) begin
      c++;
      @(negedge clk);
    end
    if (c >= 500) check("done_timeout", 1, 0);
  endtask

  int cyc, cyc2, exp1, fk;
  logic [15:0] s;

  initial begin
    reset = 1'b0; start = 1'b0; start_b = 1'b0;
    s = SEED;
    for (int k = 0; k < N; k++) begin
      vec[k] = s[2:0];
      s = ref_next(s);
    end
    exp1 = 0;
    for (int k = 0; k < N; k++) if (vec[k][0] & vec[k][1]) exp1++;

    // Hand-derived sequence from ACE1: 5670, AB38, 559C, 2ACE, 1567.
    check("vec0", vec[0], 3'd1);
    check("vec1", vec[1], 3'd0);
    check("vec2", vec[2], 3'd0);
    check("vec3", vec[3], 3'd4);
    check("vec4", vec[4], 3'd6);
    check("vec5", vec[5], 3'd7);

    repeat (3) @(negedge clk);
    check("rst_err", err_count, 0);
    check("rst_x", {x3, x2, x1}, 0);
    reset = 1'b1;
    @(negedge clk);

    mode = 0;
    start_pulse();
    wait_done(cyc);
    check("ideal_busy_len", cyc, 18);
    check("ideal_done", done, 1);
    check("ideal_pass", pass, 1);
    check("ideal_err", err_count, 0);

    mode = 1;
    start_pulse();
    wait_done(cyc);
    check("y1low_busy_len", cyc, 18);
    check("y1low_err", err_count, exp1);
    check("y1low_pass", pass, 0);

    start_pulse();
    repeat (8) @(negedge clk);
    start_pulse();
    wait_done(cyc);
    check("repulse_busy_len", cyc + 9, 18);
    check("repulse_err", err_count, exp1);

    mode = 2;
    start_pulse();
    repeat (5) @(negedge clk);
    check("abort_err_before", err_count, 3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_x", {x3, x2, x1}, 0);
    check("abort_err", err_count, 0);
    check("abort_busy", busy, 0);

    mode = 1;
    start_pulse();
    wait_done(cyc);
    check("rerun_busy_len", cyc, 18);
    check("rerun_err", err_count, exp1);

`ifdef MINI_CHK_FIRST_ERR_EN
    mode = 3;
    start_pulse();
    wait_done(cyc);
    fk = 0;
    while (fk < N - 1 && !mis(3, vec[fk])) fk++;
    check("fe_idx_model", fe_idx, fk);
    check("fe_obs_model", fe_obs, {resp(3, vec[fk]), vec[fk][1] | vec[fk][2], vec[fk][0] & vec[fk][1]});
    check("fe_idx_lit", fe_idx, 0);
    check("fe_obs_lit", fe_obs, 4'b1000);
`endif

    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc2 = 0;
    while (busy_b && cyc2 < 1000) begin
      cyc2++;
      @(negedge clk);
    end
    if (cyc2 >= 1000) check("big_timeout", 1, 0);
    check("big_busy_len", cyc2, NB + LB);
    check("big_done", done_b, 1);
    check("big_err_sat", err_b, 255);
    check("big_pass", pass_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_stim_chk.md
MINI_STIM_CHK -- requirements
Module: mini_stim_chk

Interface
REQ-001 The block SHALL have a parameter SEED with default 16'hACE1, giving the nonzero LFSR seed loaded on each start.
REQ-002 The block SHALL have a parameter NUM_VECTORS with default 16 (range 1..65535), giving the vectors applied per run.
REQ-003 The block SHALL have a parameter LATENCY with default 2 (range 1..8), giving the cycles from vector drive to response compare.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
REQ-007 x1, x2, x3  out  1 each  registered stimulus to the DUT.
REQ-008 y1, y2  in  1 each  DUT responses.
REQ-009 busy  out  1  high in RUN and DRAIN.
REQ-010 done  out  1  high in DONE.
REQ-011 pass  out  1  done AND err_count==0.
REQ-012 err_count  out  8  mismatch count, saturating.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-014 On start in IDLE or DONE, the block SHALL go to RUN, load the LFSR with SEED, clear err_count and clear the vector counter.
REQ-015 start in RUN or DRAIN SHALL be ignored.
REQ-016 The LFSR SHALL be 16-bit Fibonacci with polynomial x^16+x^14+x^13+x^11+1 and SHALL advance once per RUN cycle.
REQ-017 In RUN, {x3,x2,x1} SHALL equal LFSR[2:0], registered; outside RUN, x1..x3 SHALL be 0.
REQ-018 Per driven vector, a pipeline of depth LATENCY SHALL carry {valid=1, e1=x1&x2, e2=x2|x3}; outside RUN it SHALL carry valid=0.
REQ-019 The block SHALL compare y1/y2 against the pipeline tail exactly LATENCY cycles after the vector is driven, and only when the tail is valid.
REQ-020 Any mismatch (y1!=e1 or y2!=e2) SHALL increment err_count by 1 per cycle, saturating at 255.
REQ-021 RUN SHALL last exactly NUM_VECTORS cycles and then transition to DRAIN.
REQ-022 DRAIN SHALL last exactly LATENCY cycles, with compares continuing, and then transition to DONE.
REQ-023 DONE SHALL hold err_count and pass until the next start.

Reset
REQ-024 When reset=0 at a clock edge: state=IDLE, x1..x3=0, busy=0, done=0, pass=0, err_count=0, pipeline valid bits=0, LFSR=SEED.
REQ-025 A reset in any state, including mid-RUN or mid-DRAIN, SHALL abort the run with no compare performed in that cycle.

Configuration
REQ-026 With MINI_CHK_FIRST_ERR_EN defined, the block SHALL add outputs first_err_idx (16 bits, vector index) and first_err_obs (4 bits, {y2,y1,e2,e1}), both captured on the first mismatch of a run, held until the next start, and cleared by reset/start.
REQ-027 With MINI_CHK_FIRST_ERR_EN undefined, these ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package mini_pkg SHALL hold the FSM state enum, the LFSR width/tap constant, the err_count width and the saturation value.
REQ-029 The LFSR SHALL be sub-module mini_lfsr, with ports clk, reset, load, en, seed and q.

Verification
REQ-030 Ideal 2-cycle model on y, NUM_VECTORS=16, one start pulse -> busy for 18 cycles, then done=1, pass=1, err_count=0.
REQ-031 y1 forced to 0 -> err_count equals the number of vectors with x1&x2=1, and pass=0.
REQ-032 y1,y2 inverted, NUM_VECTORS=300 -> err_count=255 (saturated) at done.
REQ-033 reset=0 at RUN cycle 5 -> next cycle IDLE, x1..x3=0, err_count=0; a later start reruns the same vectors from SEED.
REQ-034 start repulsed during RUN -> run length unchanged, err_count not cleared.
REQ-035 With MINI_CHK_FIRST_ERR_EN, y2 forced to 1 -> first_err_idx equals the first vector index with x2=x3=0, and first_err_obs={1,y1,0,e1}.
